exception_ctrl: RTL and testbench
=================================

Name: exception_ctrl

Overview:
Sequences exception and interrupt entry for the pipelined core. It latches external interrupt requests, applies an enable mask and fixed priority, and waits for a safe pipeline point. It then produces the one-cycle takenHandler pulse and the EPC value consumed by the next-PC/branch logic. It blocks further entry until the handler executes ERET.

Parameters:
N_IRQ, 8, number of external interrupt lines (1..16)
XLEN, 64, PC/EPC width

Ports:
clock  in  1  core clock, rising edge
reset_n  in  1  asynchronous active-low reset
irq  in  N_IRQ  interrupt lines, synchronous to clock, rising-edge sensitive
mask_we  in  1  write enable for interrupt mask
mask_wdata  in  N_IRQ  new mask value (1 = enabled)
exc_valid  in  1  synchronous exception raised by EX-stage instruction (overflow, syscall)
exc_code  in  5  cause code for exc_valid (nonzero)
exc_pc  in  XLEN  PC of faulting instruction
ex_valid  in  1  EX stage holds a real (non-bubble) instruction
ex_pc  in  XLEN  PC of instruction in EX
branch_pending  in  1  EX resolves a taken branch/jump this cycle
stall  in  1  pipeline stalled this cycle
eret  in  1  ERET decoded in ID
takenHandler  out  1  one-cycle redirect-to-handler pulse
EPC  out  XLEN  return address for ERET
cause_code  out  5  code of last taken event (0 = interrupt)
cause_irq  out  4  index of taken interrupt (valid when cause_code==0)
in_handler  out  1  handler active, entry blocked
pending  out  N_IRQ  sticky pending interrupt bits
double_fault  out  1  sticky: exc_valid seen while in_handler

Behaviour:
- Reset (async, reset_n=0): state IDLE; pending, mask, EPC, cause_code, cause_irq, double_fault = 0; takenHandler=0 and in_handler=0 immediately. Reset mid-TAKE drops the pulse in the same cycle.
- irq edge detect: previous-irq register. A 0->1 transition on line i sets pending[i] next cycle. A level held high sets pending only once.
- pending[i] clears on the cycle interrupt i is captured. If a new edge on i arrives in that same cycle, the set wins.
- mask: written on mask_we. A capture in the same cycle uses the old mask.
- Request: exc_valid OR |(pending & mask).
- Priority: exception over interrupt; among interrupts, the lowest index wins.
- FSM states: IDLE, WAIT, TAKE, HANDLER.
- IDLE/WAIT with exc_valid:
  - EPC <= exc_pc, cause_code <= exc_code.
  - Next state TAKE, regardless of stall or branch_pending.
- IDLE/WAIT with an interrupt request only:
  - Safe point = ex_valid & ~branch_pending & ~stall.
  - If safe: EPC <= ex_pc, cause_code <= 0, cause_irq <= winner index, clear pending[winner], next state TAKE.
  - If not safe: next state WAIT, re-evaluated every cycle with no timeout.
  - Masking all pending bits while in WAIT returns to IDLE.
- TAKE: takenHandler = 1 for exactly this cycle, registered (state decode only); next state HANDLER.
- HANDLER:
  - in_handler = 1; new interrupts accumulate in pending but are not taken.
  - exc_valid sets double_fault; there is no entry and EPC is unchanged.
  - eret -> IDLE next cycle; in_handler drops that cycle.
  - eret in any other state is ignored.
- Latency: exc_valid at cycle t -> takenHandler at t+1. irq edge at t -> pending at t+1 -> takenHandler at t+2 if safe.
- EPC holds its value outside capture cycles so ERET reads a stable value.

Test Plan:
- Reset, mask=0x01, irq[0] pulse at cycle 10, ex_valid=1 with ex_pc=0x400, no stall -> pending[0]=1 at 11, takenHandler=1 only at 12, EPC=0x400, cause_code=0, cause_irq=0, pending[0]=0, in_handler=1 from 13.
- mask=0xFF, irq[5] and irq[2] rise together -> cause_irq=2 and pending=0x20 after entry. eret -> IDLE. irq[5] is then taken with no new edge.
- Interrupt pending with stall=1 for 4 cycles (or branch_pending=1) -> no takenHandler until the first safe cycle, then a single pulse with EPC=that cycle's ex_pc.
- exc_valid with exc_code=12, exc_pc=0x1008 in the same cycle as a pending enabled interrupt -> takenHandler next cycle, cause_code=12, EPC=0x1008, interrupt stays pending.
- In HANDLER, exc_valid -> double_fault=1, no pulse, EPC unchanged. eret -> in_handler=0 next cycle.
- reset_n low during TAKE -> takenHandler falls immediately, all outputs 0, and after release no entry until a new irq edge.

Source files
------------

// File: rtl/exception_ctrl.sv
// exception_ctrl: latches interrupts, prioritises exceptions and interrupts, and sequences handler entry and exit.
module exception_ctrl #(
  parameter int N_IRQ = 8,
  parameter int XLEN  = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_IRQ-1:0] irq,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             exc_valid,
  input  logic [4:0]       exc_code,
  input  logic [XLEN-1:0]  exc_pc,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             branch_pending,
  input  logic             stall,
  input  logic             eret,
  output logic             takenHandler,
  output logic [XLEN-1:0]  EPC,
  output logic [4:0]       cause_code,
  output logic [3:0]       cause_irq,
  output logic             in_handler,
  output logic [N_IRQ-1:0] pending,
  output logic             double_fault
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TAKE, S_HANDLER} state_t;
  state_t state, state_nx;
  logic [N_IRQ-1:0] irq_q, mask, rise, req_vec, win_oh, clr;
  logic [3:0] win_idx;
  logic idle_like, safe, req_irq, cap_exc, cap_irq;
  assign rise      = irq & ~irq_q;
  assign req_vec   = pending & mask;
  assign req_irq   = |req_vec;
  assign win_oh    = req_vec & (~req_vec + 1'b1);
  assign safe      = ex_valid & ~branch_pending & ~stall;
  assign idle_like = (state == S_IDLE) || (state == S_WAIT);
  assign cap_exc   = idle_like & exc_valid;
  assign cap_irq   = idle_like & ~exc_valid & req_irq & safe;
  assign clr       = cap_irq ? win_oh : '0;
  assign takenHandler = (state == S_TAKE);
  assign in_handler   = (state == S_HANDLER);
  always_comb begin
    win_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (req_vec[i]) win_idx = 4'(i);
  end
  always_comb begin
    state_nx = state;
    if (idle_like)
      state_nx = exc_valid ? S_TAKE : !req_irq ? S_IDLE : safe ? S_TAKE : S_WAIT;
    else if (state == S_TAKE)
      state_nx = S_HANDLER;
    else
      state_nx = eret ? S_IDLE : S_HANDLER;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      irq_q        <= '0;
      pending      <= '0;
      mask         <= '0;
      EPC          <= '0;
      cause_code   <= '0;
      cause_irq    <= '0;
      double_fault <= 1'b0;
    end else begin
      state        <= state_nx;
      irq_q        <= irq;
      // a fresh edge on the line being captured re-arms it
      pending      <= (pending & ~clr) | rise;
      mask         <= mask_we ? mask_wdata : mask;
      EPC          <= cap_exc ? exc_pc : cap_irq ? ex_pc : EPC;
      cause_code   <= cap_exc ? exc_code : cap_irq ? 5'd0 : cause_code;
      cause_irq    <= cap_irq ? win_idx : cause_irq;
      double_fault <= double_fault | (in_handler & exc_valid);
    end
  end
endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl: directed checks of interrupt/exception entry, priority, safe-point waiting and reset.
module tb_exception_ctrl;
  logic        clock, reset_n;
  logic [7:0]  irq, mask_wdata, pending;
  logic        mask_we, exc_valid, ex_valid, branch_pending, stall, eret;
  logic [4:0]  exc_code, cause_code;
  logic [63:0] exc_pc, ex_pc, EPC;
  logic        takenHandler, in_handler, double_fault;
  logic [3:0]  cause_irq;
  int errors = 0;
  int checks = 0;

  exception_ctrl #(.N_IRQ(8), .XLEN(64)) dut (
    .clock(clock), .reset_n(reset_n), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .branch_pending(branch_pending), .stall(stall), .eret(eret), .takenHandler(takenHandler),
    .EPC(EPC), .cause_code(cause_code), .cause_irq(cause_irq), .in_handler(in_handler),
    .pending(pending), .double_fault(double_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mask(input logic [7:0] m);
    mask_we = 1'b1; mask_wdata = m;
    tick();
    mask_we = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; irq = '0; mask_we = 1'b0; mask_wdata = '0; exc_valid = 1'b0; exc_code = '0;
    exc_pc = '0; ex_valid = 1'b0; ex_pc = '0; branch_pending = 1'b0; stall = 1'b0; eret = 1'b0;
    #1;
    chk("rst_taken", takenHandler, 0);
    chk("rst_inh", in_handler, 0);
    chk("rst_pending", pending, 0);
    chk("rst_epc", EPC, 0);
    chk("rst_df", double_fault, 0);
    tick(); tick();
    #4 reset_n = 1'b1;
    tick();

    // single interrupt, safe immediately
    set_mask(8'h01);
    ex_valid = 1'b1; ex_pc = 64'h400;
    irq = 8'h01;
    tick();
    irq = 8'h00;
    chk("t1_pending_set", pending, 8'h01);
    chk("t1_no_pulse_yet", takenHandler, 0);
    tick();
    chk("t1_pulse", takenHandler, 1);
    chk("t1_epc", EPC, 64'h400);
    chk("t1_cause", cause_code, 0);
    chk("t1_irq_idx", cause_irq, 0);
    chk("t1_pending_clr", pending, 0);
    chk("t1_inh_take", in_handler, 0);
    tick();
    chk("t1_pulse_once", takenHandler, 0);
    chk("t1_inh", in_handler, 1);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("t1_eret", in_handler, 0);

    // priority: lowest index wins, the other stays pending
    set_mask(8'hFF);
    irq = 8'h24;
    tick();
    irq = 8'h00;
    chk("t2_pending", pending, 8'h24);
    tick();
    chk("t2_pulse", takenHandler, 1);
    chk("t2_idx", cause_irq, 2);
    chk("t2_pending_left", pending, 8'h20);
    tick();
    chk("t2_hold_no_pulse", takenHandler, 0);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("t2_eret", in_handler, 0);
    tick();
    chk("t2_second_pulse", takenHandler, 1);
    chk("t2_second_idx", cause_irq, 5);
    chk("t2_pending_empty", pending, 0);
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;

    // unsafe cycles defer entry
    stall = 1'b1;
    irq = 8'h08;
    tick();
    irq = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_stall_no_pulse", takenHandler, 0);
    end
    stall = 1'b0; branch_pending = 1'b1; ex_pc = 64'h510;
    tick();
    chk("t3_branch_no_pulse", takenHandler, 0);
    branch_pending = 1'b0; ex_pc = 64'h520;
    tick();
    chk("t3_pulse", takenHandler, 1);
    chk("t3_epc", EPC, 64'h520);
    chk("t3_idx", cause_irq, 3);
    tick();
    chk("t3_single_pulse", takenHandler, 0);
    eret = 1'b1;
    tick();
    eret = 1'b0;

    // exception beats a pending interrupt, even while stalled
    stall = 1'b1;
    irq = 8'h02;
    tick();
    irq = 8'h00;
    tick();
    exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 64'h1008;
    tick();
    exc_valid = 1'b0;
    chk("t4_pulse", takenHandler, 1);
    chk("t4_cause", cause_code, 12);
    chk("t4_epc", EPC, 64'h1008);
    chk("t4_irq_kept", pending, 8'h02);
    tick();

    // exception inside the handler
    exc_valid = 1'b1; exc_code = 5'd3; exc_pc = 64'h2000;
    tick();
    exc_valid = 1'b0;
    chk("t5_df", double_fault, 1);
    chk("t5_no_pulse", takenHandler, 0);
    chk("t5_epc_kept", EPC, 64'h1008);
    chk("t5_cause_kept", cause_code, 12);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("t5_eret", in_handler, 0);

    // masking everything while waiting cancels entry
    set_mask(8'h00);
    stall = 1'b0;
    tick();
    chk("t5_masked_no_pulse", takenHandler, 0);
    tick();
    chk("t5_masked_no_pulse2", takenHandler, 0);
    chk("t5_masked_pending", pending, 8'h02);
    stall = 1'b1;
    set_mask(8'hFF);
    stall = 1'b0;
    tick();
    chk("t5_unmask_pulse", takenHandler, 1);
    chk("t5_unmask_idx", cause_irq, 1);
    chk("t5_unmask_cause", cause_code, 0);
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;

    // async reset in the middle of the pulse
    irq = 8'h01;
    tick();
    irq = 8'h00;
    tick();
    chk("t6_pulse", takenHandler, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_pulse", takenHandler, 0);
    chk("t6_rst_inh", in_handler, 0);
    chk("t6_rst_epc", EPC, 0);
    chk("t6_rst_df", double_fault, 0);
    chk("t6_rst_pending", pending, 0);
    #2 reset_n = 1'b1;
    set_mask(8'h01);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_entry", takenHandler, 0);
    end
    irq = 8'h01; ex_pc = 64'h800;
    tick();
    irq = 8'h00;
    tick();
    chk("t6_new_pulse", takenHandler, 1);
    chk("t6_new_epc", EPC, 64'h800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
